// File: rtl/tone_pkg.sv
// Shared definitions for the tone player: note frequency table, state
// encoding and the half-period helper used to build the tone table.
// Optional feature macro: TONE_PLAYER_GAP_EN adds the GAP state.
package tone_pkg;

  localparam int NUM_NOTES = 28;

  // Semitones C4 .. D#6, rounded to whole Hz.
  localparam int unsigned NOTE_HZ [NUM_NOTES] = '{
    262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494,
    523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988,
    1047, 1109, 1175, 1245
  };

`ifdef TONE_PLAYER_GAP_EN
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;
`else
  typedef enum logic [1:0] {IDLE, PLAY} state_e;
`endif

  // Clock cycles between toggles of the square wave for a given note.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned code);
    return clk_hz / (2 * NOTE_HZ[code]);
  endfunction

endpackage

// File: rtl/tone_player_if.sv
// Note-event handshake between a producer and the tone player.
interface tone_player_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 12
);
  logic              note_valid;
  logic              note_ready;
  logic [NOTE_W-1:0] note_code;
  logic [DUR_W-1:0]  note_dur;

  modport master (output note_valid, output note_code, output note_dur,
                  input note_ready);
  modport slave  (input note_valid, input note_code, input note_dur,
                  output note_ready);
endinterface

// File: rtl/tone_fifo.sv
// Note queue: power-of-two depth, pointers wrap naturally, flush empties
// the queue and wins over push and pop in the same cycle.
module tone_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // Next pointers and occupancy.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
      else if (pop_ok && !push_ok) level_d = level_q - LW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/tone_player.sv
// Queued square-wave tone player. Notes (code, duration in ms) are queued
// through the handshake interface and played in order; codes 0..27 are
// semitones C4..D#6, larger codes are rests.
// Optional feature macro: TONE_PLAYER_GAP_EN inserts a silent GAP_MS gap
// after every played note.
module tone_player
  import tone_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DEPTH  = 8,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 12
`ifdef TONE_PLAYER_GAP_EN
  , parameter int GAP_MS = 20
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tone_player_if.slave           note_if,
  input  logic                   flush,
  output logic                   sound,
  output logic                   busy,
  output logic                   note_done,
  output logic [$clog2(DEPTH):0] level
);

  localparam int MS_CYC = CLK_HZ / 1000;
  localparam int PRE_W  = $clog2(MS_CYC + 1);
  // Lowest note has the longest half period and sizes the counter.
  localparam int HC_W   = $clog2(half_period(CLK_HZ, 0) + 1);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int ENT_W  = NOTE_W + DUR_W;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_CYC - 1);
`ifdef TONE_PLAYER_GAP_EN
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);
`endif

  state_e             state_q, state_d;
  logic               head_vld_q, head_vld_d;
  logic               sound_q, sound_d;
  logic               done_q, done_d;
  logic               rdy_en_q, rdy_en_d;
  logic [HC_W-1:0]    hc_q, hc_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [DUR_W-1:0]   ms_q, ms_d;
  logic [NOTE_W-1:0]  cur_code_q, cur_code_d;
  logic [DUR_W-1:0]   cur_dur_q, cur_dur_d;

  logic               ready, push, pop, load, restart;
  logic               fifo_full, fifo_empty;
  logic [ENT_W-1:0]   head;
  logic [NOTE_W-1:0]  head_code;
  logic [DUR_W-1:0]   head_dur;
  logic [LVL_W-1:0]   fifo_level;
  logic [HC_W-1:0]    half_tbl [NUM_NOTES];
  logic [HC_W-1:0]    half_lim;
  logic               is_tone, ms_tick, play_last, head_ok;

  // Ready comes only from registered occupancy plus the flush input; it
  // stays low until the first clock edge after reset releases.
  assign rdy_en_d           = 1'b1;
  assign ready              = rdy_en_q && !fifo_full && !flush;
  assign note_if.note_ready = ready;
  assign push               = note_if.note_valid && ready;
  assign {head_code, head_dur} = head;

  tone_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({note_if.note_code, note_if.note_dur}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Half-period reload values, fixed at elaboration (stored minus one).
  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_half
    assign half_tbl[g] = HC_W'(half_period(CLK_HZ, g) - 1);
  end

  // Look up the current note; codes past the table are rests.
  always_comb begin
    half_lim = '0;
    is_tone  = 1'b0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (int'(cur_code_q) == i) begin
        half_lim = half_tbl[i];
        is_tone  = 1'b1;
      end
    end
  end

  assign ms_tick   = (pre_q == PRE_LAST);
  assign play_last = ms_tick && (ms_q == cur_dur_q - DUR_W'(1));
  // A zero-duration head cannot start PLAY directly; IDLE retires it.
  assign head_ok   = !fifo_empty && (head_dur != '0);

  // Next-state, counters and outputs of the playback FSM.
  always_comb begin
    state_d    = state_q;
    head_vld_d = head_vld_q;
    sound_d    = sound_q;
    done_d     = 1'b0;
    hc_d       = hc_q;
    pre_d      = pre_q;
    ms_d       = ms_q;
    pop        = 1'b0;
    load       = 1'b0;
    restart    = 1'b0;
    if (flush) begin
      state_d    = IDLE;
      head_vld_d = 1'b0;
      restart    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // Pop into the note register first, start it one edge later.
          if (head_vld_q) begin
            head_vld_d = 1'b0;
            if (cur_dur_q == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = PLAY;
              restart = 1'b1;
            end
          end else if (!fifo_empty) begin
            pop        = 1'b1;
            load       = 1'b1;
            head_vld_d = 1'b1;
          end
        end
        PLAY: begin
          if (play_last) begin
            done_d  = 1'b1;
            restart = 1'b1;
`ifdef TONE_PLAYER_GAP_EN
            state_d = GAP;
`else
            if (head_ok) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
`endif
          end else begin
            if (ms_tick) begin
              pre_d = '0;
              ms_d  = ms_q + DUR_W'(1);
            end else begin
              pre_d = pre_q + PRE_W'(1);
            end
            if (is_tone) begin
              if (hc_q == half_lim) begin
                hc_d    = '0;
                sound_d = !sound_q;
              end else begin
                hc_d = hc_q + HC_W'(1);
              end
            end
          end
        end
`ifdef TONE_PLAYER_GAP_EN
        GAP: begin
          if (ms_tick && (ms_q == GAP_LAST)) begin
            restart = 1'b1;
            if (head_ok) begin
              pop     = 1'b1;
              load    = 1'b1;
              state_d = PLAY;
            end else begin
              state_d = IDLE;
            end
          end else if (ms_tick) begin
            pre_d = '0;
            ms_d  = ms_q + DUR_W'(1);
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
    if (restart) begin
      hc_d    = '0;
      pre_d   = '0;
      ms_d    = '0;
      sound_d = 1'b0;
    end
  end

  assign cur_code_d = load ? head_code : cur_code_q;
  assign cur_dur_d  = load ? head_dur  : cur_dur_q;

  // Control state; reset abandons any note in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      head_vld_q <= 1'b0;
      sound_q    <= 1'b0;
      done_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
      hc_q       <= '0;
      pre_q      <= '0;
      ms_q       <= '0;
    end else begin
      state_q    <= state_d;
      head_vld_q <= head_vld_d;
      sound_q    <= sound_d;
      done_q     <= done_d;
      rdy_en_q   <= rdy_en_d;
      hc_q       <= hc_d;
      pre_q      <= pre_d;
      ms_q       <= ms_d;
    end
  end

  // Current note payload; only meaningful once loaded from the queue.
  always_ff @(posedge clk) begin
    cur_code_q <= cur_code_d;
    cur_dur_q  <= cur_dur_d;
  end

  assign sound     = sound_q;
  assign note_done = done_q;
  assign level     = fifo_level;
  assign busy      = (state_q != IDLE) || !fifo_empty || head_vld_q;

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player at CLK_HZ=1 MHz (1 ms = 1000 cycles), DEPTH=4.
module tb_tone_player;

  localparam int NW = 6;
  localparam int DW = 12;
`ifdef TONE_PLAYER_GAP_EN
  localparam int GAP_CYC = 20000;
`else
  localparam int GAP_CYC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       sound, busy, note_done;
  logic [2:0] level;

  tone_player_if #(.NOTE_W(NW), .DUR_W(DW)) nif ();

  tone_player #(
    .CLK_HZ (1_000_000),
    .DEPTH  (4),
    .NOTE_W (NW),
    .DUR_W  (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .note_if   (nif),
    .flush     (flush),
    .sound     (sound),
    .busy      (busy),
    .note_done (note_done),
    .level     (level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log: cycle numbers (rising-edge count) of sound changes and done pulses.
  int   tog_q[$];
  int   done_q[$];
  logic snd_prev = 1'b0;
  always @(negedge clk) begin
    if (sound !== snd_prev) tog_q.push_back(cyc);
    snd_prev = sound;
    if (note_done === 1'b1) done_q.push_back(cyc);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance
  // with acc = index of the accepting rising edge.
  task automatic push_note(input logic [NW-1:0] c, input logic [DW-1:0] d, output int acc);
    int w;
    nif.note_valid = 1'b1;
    nif.note_code  = c;
    nif.note_dur   = d;
    w = 0;
    while (!nif.note_ready && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("push_ready", {31'd0, nif.note_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    nif.note_valid = 1'b0;
  endtask

  task automatic clear_log();
    tog_q.delete();
    done_q.delete();
  endtask

  initial begin
    int a, t, nd, nt, w;
    nif.note_valid = 1'b0;
    nif.note_code  = '0;
    nif.note_dur   = '0;
    flush = 1'b0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, nif.note_ready}, 0);
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_level", {29'd0, level}, 0);
    chk("rst_sound", {31'd0, sound}, 0);
    chk("rst_done",  {31'd0, note_done}, 0);
    rst_n = 1'b1;
    #1 chk("rdy_before_edge", {31'd0, nif.note_ready}, 0);
    @(negedge clk);
    chk("rdy_after_edge", {31'd0, nif.note_ready}, 1);

    // A4 (code 9), 3 ms: PLAY from accept+2, half period 1136
    clear_log();
    push_note(6'd9, 12'd3, a);
    chk("t1_level", {29'd0, level}, 1);
    chk("t1_busy", {31'd0, busy}, 1);
    repeat (3100) @(negedge clk);
    chk("t1_tog_n", tog_q.size(), 2);
    chk("t1_tog0", q_at(tog_q, 0) - a, 1138);
    chk("t1_tog1", q_at(tog_q, 1) - a, 2274);
    chk("t1_done_n", done_q.size(), 1);
    chk("t1_done_at", q_at(done_q, 0) - a, 3002);
    chk("t1_sound", {31'd0, sound}, 0);
    chk("t1_busy_end", {31'd0, busy}, 0);

    // Queue fills while a 1 ms rest plays; 5th push waits for the next pop
    clear_log();
    push_note(6'd40, 12'd1, a);
    repeat (200) @(negedge clk);
    for (int i = 0; i < 4; i++) push_note(6'd40, 12'd1, t);
    chk("t2_level_full", {29'd0, level}, 4);
    nif.note_valid = 1'b1;
    nif.note_code  = 6'd40;
    nif.note_dur   = 12'd1;
    chk("t2_ready_full", {31'd0, nif.note_ready}, 0);
    w = 0;
    while (!nif.note_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("t2_ready_rise", {31'd0, nif.note_ready}, 1);
    chk("t2_pop_cycle", cyc - a, 1002);
    chk("t2_level_pop", {29'd0, level}, 3);
    @(posedge clk);
    @(negedge clk);
    nif.note_valid = 1'b0;
    chk("t2_level_refill", {29'd0, level}, 4);
    chk("t2_done_n", done_q.size(), 1);
    chk("t2_sound_rest", tog_q.size(), 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t2_flush_level", {29'd0, level}, 0);
    repeat (10) @(negedge clk);

    // Rest code 40 for 2 ms
    clear_log();
    push_note(6'd40, 12'd2, a);
    repeat (2100) @(negedge clk);
    chk("t3_tog_n", tog_q.size(), 0);
    chk("t3_done_n", done_q.size(), 1);
    chk("t3_done_at", q_at(done_q, 0) - a, 2002);
    chk("t3_busy_end", {31'd0, busy}, 0);

    // Zero-duration note then C4 (half period 1908) for 5 ms
    clear_log();
    push_note(6'd5, 12'd0, a);
    push_note(6'd0, 12'd5, t);
    repeat (5100) @(negedge clk);
    chk("t4_done_n", done_q.size(), 2);
    chk("t4_done0_at", q_at(done_q, 0) - a, 2);
    chk("t4_done1_at", q_at(done_q, 1) - a, 5004);
    chk("t4_tog_n", tog_q.size(), 2);
    chk("t4_tog0", q_at(tog_q, 0) - a, 1912);
    chk("t4_half", q_at(tog_q, 1) - q_at(tog_q, 0), 1908);
    chk("t4_sound", {31'd0, sound}, 0);

    // Flush 500 cycles into D#6 (half period 401) with two notes queued
    clear_log();
    push_note(6'd27, 12'd5, a);
    push_note(6'd40, 12'd1, t);
    push_note(6'd40, 12'd1, t);
    repeat (500) @(negedge clk);
    chk("t5_pre_sound", {31'd0, sound}, 1);
    chk("t5_pre_level", {29'd0, level}, 2);
    nd = done_q.size();
    flush = 1'b1;
    nif.note_valid = 1'b1;
    nif.note_code  = 6'd9;
    nif.note_dur   = 12'd1;
    #1 chk("t5_ready_flush", {31'd0, nif.note_ready}, 0);
    @(negedge clk);
    flush = 1'b0;
    nif.note_valid = 1'b0;
    chk("t5_sound", {31'd0, sound}, 0);
    chk("t5_level", {29'd0, level}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    @(negedge clk);
    nt = tog_q.size();
    repeat (3000) @(negedge clk);
    chk("t5_no_done", done_q.size(), nd);
    chk("t5_quiet", tog_q.size(), nt);

    // Reset mid-note
    clear_log();
    push_note(6'd27, 12'd3, a);
    push_note(6'd40, 12'd1, t);
    push_note(6'd40, 12'd1, t);
    repeat (600) @(negedge clk);
    chk("t6_pre_sound", {31'd0, sound}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_sound", {31'd0, sound}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_level", {29'd0, level}, 0);
    chk("t6_ready", {31'd0, nif.note_ready}, 0);
    chk("t6_done", {31'd0, note_done}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = done_q.size();
    repeat (3000) @(negedge clk);
    chk("t6_no_done", done_q.size(), nd);
    chk("t6_idle", {31'd0, busy}, 0);

    // Two notes in sequence; GAP_CYC silent cycles between them when enabled
    clear_log();
    push_note(6'd40, 12'd1, a);
    push_note(6'd9, 12'd2, t);
    repeat (1002 + GAP_CYC + 2100) @(negedge clk);
    chk("t7_done_n", done_q.size(), 2);
    chk("t7_done0_at", q_at(done_q, 0) - a, 1002);
    chk("t7_done1_at", q_at(done_q, 1) - a, 1002 + GAP_CYC + 2000);
    chk("t7_tog_n", tog_q.size(), 2);
    chk("t7_tog0", q_at(tog_q, 0) - a, 1002 + GAP_CYC + 1136);
    chk("t7_tog1", q_at(tog_q, 1) - a, 1002 + GAP_CYC + 2000);
    chk("t7_busy_end", {31'd0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
